// File: rtl/offchip_lane_buffer.sv
// Lane-interleaving split/reassemble path: words -> LINK_W beats -> circular beat buffer -> words.
// Define OFFCHIP_LANE_PARITY_EN to store an even-parity bit per beat and flag mismatches on pop.
module offchip_lane_buffer #(
    parameter int DATA_W = 64,
    parameter int LINK_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     parity_err
);
    localparam int NBEATS = DATA_W / LINK_W;
    localparam int H      = LINK_W / 2;
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + 1;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LAST   = NBEATS - 1;
`ifdef OFFCHIP_LANE_PARITY_EN
    localparam int MW     = LINK_W + 1;
`else
    localparam int MW     = LINK_W;
`endif

    // S_IDLE: no word held | S_SPLIT: writing beat bidx_q of word_q
    typedef enum logic {S_IDLE, S_SPLIT} wstate_t;

    wstate_t             state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [BW-1:0]       bidx_q, bidx_d;
    logic [PW-1:0]       wptr_q, rptr_q, credits_q;
    logic [BW-1:0]       gidx_q;
    logic [LINK_W-1:0]   gather_q [NBEATS-1];
    logic [DATA_W-1:0]   dout_q;
    logic                vout_q;
    logic [MW-1:0]       mem_q [DEPTH];

    logic                accept, wr_en, pop, gather_last, load_out, last_beat;
    logic [LINK_W-1:0]   beat_w, rd_beat;
    logic [MW-1:0]       wr_word, rd_word;
    logic [DATA_W-1:0]   assembled;

    assign last_beat = (bidx_q == BW'(LAST));
    assign ready_in  = (credits_q >= PW'(NBEATS)) && (state_q == S_IDLE || last_beat) && !rst;
    assign accept    = valid_in && ready_in;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bidx_d  = bidx_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SPLIT;
                    word_d  = data_in;
                    bidx_d  = '0;
                end
            end
            S_SPLIT: begin
                wr_en = 1'b1;
                if (!last_beat) begin
                    bidx_d = bidx_q + BW'(1);
                end else if (accept) begin
                    word_d = data_in;
                    bidx_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb beat_w = {word_q[DATA_W/2 + int'(bidx_q)*H +: H], word_q[int'(bidx_q)*H +: H]};

`ifdef OFFCHIP_LANE_PARITY_EN
    assign wr_word = {^beat_w, beat_w};
`else
    assign wr_word = beat_w;
`endif

    assign rd_word     = mem_q[rptr_q[AW-1:0]];
    assign rd_beat     = rd_word[LINK_W-1:0];
    assign level       = wptr_q - rptr_q;
    assign gather_last = (gidx_q == BW'(LAST));
    // The final beat may only leave the buffer when the output register can take the word.
    assign pop         = (level != '0) && (!gather_last || !vout_q || ready_out);
    assign load_out    = pop && gather_last;

    always_comb begin
        assembled = '0;
        for (int k = 0; k < LAST; k++) begin
            assembled[DATA_W/2 + k*H +: H] = gather_q[k][LINK_W-1:H];
            assembled[k*H +: H]            = gather_q[k][H-1:0];
        end
        assembled[DATA_W/2 + LAST*H +: H] = rd_beat[LINK_W-1:H];
        assembled[LAST*H +: H]            = rd_beat[H-1:0];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wr_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            bidx_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            credits_q <= PW'(DEPTH);
            gidx_q    <= '0;
            for (int k = 0; k < LAST; k++) gather_q[k] <= '0;
            dout_q    <= '0;
            vout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            bidx_q    <= bidx_d;
            credits_q <= credits_q + PW'(pop) - (accept ? PW'(NBEATS) : PW'(0));
            if (wr_en) wptr_q <= wptr_q + PW'(1);
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
                gidx_q <= gather_last ? '0 : gidx_q + BW'(1);
            end
            for (int k = 0; k < LAST; k++) begin
                if (pop && gidx_q == BW'(k)) gather_q[k] <= rd_beat;
            end
            if (load_out) begin
                dout_q <= assembled;
                vout_q <= 1'b1;
            end else if (ready_out) begin
                vout_q <= 1'b0;
            end
        end
    end

    assign data_out  = dout_q;
    assign valid_out = vout_q;

`ifdef OFFCHIP_LANE_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    perr_q <= 1'b0;
        else if (pop && ^rd_word)   perr_q <= 1'b1;
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
